// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: a circular FIFO feeds a START/DATA/STOP framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_stream #(
  parameter int CLK_DIV    = 1042,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clock,
  input  logic                            resetb,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            tx_en,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [2:0]                      fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [15:0]     div_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push;
  logic            pop;
  logic            bit_done;
  logic            frame_next;

  // in_valid/in_ready: a byte transfers on any rising edge where both are high;
  // in_ready depends only on the buffer fill level, never on in_valid.
  assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign bit_done   = (div_cnt == 16'd0);
  assign frame_next = (fifo_count != '0) && tx_en;
  assign pop        = frame_next && ((state == IDLE) || ((state == STOP) && bit_done));
  assign fsm_state  = state;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      // Every bit lasts CLK_DIV cycles: count down, reload at each boundary.
      if (state != IDLE && !bit_done) div_cnt <= div_cnt - 16'd1;
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= RELOAD;
            shreg   <= mem[rd_ptr];
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= 3'd0;
            div_cnt <= RELOAD;
          end
        end
        DATA: begin
          if (bit_done) begin
            div_cnt <= RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shreg;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx      <= 1'b1;
            div_cnt <= RELOAD;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              state   <= START;
              tx      <= 1'b0;
              div_cnt <= RELOAD;
              shreg   <= mem[rd_ptr];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: a queue-based line model checked every cycle,
// plus directed scenarios with hand-computed waveforms and counts.
module tb_uart_tx_stream;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic       clock;
  logic       resetb;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_en;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic [2:0] fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_stream #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .resetb(resetb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_en(tx_en), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: buffered bytes, and the line levels still to be shown (head = now).
  logic [7:0] model_fifo[$];
  logic [0:0] exp_q[$];
  logic       m_full;
  logic [7:0] m_byte;

  task automatic append_frame(input logic [7:0] d);
    logic [0:0] lv[$];
    lv.push_back(1'b0);
    for (int b = 0; b < 8; b++) lv.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    lv.push_back(^d);
`endif
    lv.push_back(1'b1);
    foreach (lv[k]) for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(lv[k]);
  endtask

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      model_fifo.delete();
      exp_q.delete();
    end else begin
      m_full = (model_fifo.size() == DEPTH);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && model_fifo.size() > 0 && tx_en) begin
        m_byte = model_fifo.pop_front();
        append_frame(m_byte);
      end
      if (in_valid && !m_full) model_fifo.push_back(in_data);
    end
  end

  always @(negedge clock) begin
    check("model_tx", tx, (exp_q.size() > 0) ? exp_q[0] : 1'b1);
    check("model_busy", busy, exp_q.size() > 0);
    check("model_fifo_count", fifo_count, model_fifo.size());
    check("model_in_ready", in_ready, model_fifo.size() != DEPTH);
  end

  // driver tasks
  task automatic frame_check(input logic [7:0] d, input logic [10:0] lvl, input int nb);
    int busy_n;
    busy_n   = 0;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < nb * CLK_DIV; i++) begin
      tick();
      check("frame_tx_level", tx, lvl[i / CLK_DIV]);
      if (busy) busy_n++;
    end
    tick();
    check("frame_busy_after", busy, 0);
    check("frame_busy_cycles", busy_n, nb * CLK_DIV);
  endtask

  task automatic wait_drain(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_within_bound", done, 1);
  endtask

  initial begin
    logic [7:0] rx;
    int run;
    logic seen_busy;
    resetb   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_en    = 1'b0;
    repeat (3) tick();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_state_idle", fsm_state, 0);
    resetb = 1'b1;
    tick();

    // single frames with literal waveforms
    tx_en = 1'b1;
`ifdef UART_TX_PARITY_EN
    frame_check(8'h07, 11'b11000001110, 11);
    frame_check(8'hA5, 11'b10100101010, 11);
`else
    frame_check(8'hA5, 11'b01101001010, 10);
`endif

    // fill with tx_en low, then release and decode the line
    tx_en    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("fill_fifo_count", fifo_count, 8);
    check("fill_in_ready", in_ready, 0);
    check("fill_tx_idle", tx, 1);
    tx_en = 1'b1;
    rx    = 8'h00;
    for (int c = 0; c < 8 * FRAME_CYC; c++) begin
      int pos;
      tick();
      pos = c % FRAME_CYC;
      if ((pos % CLK_DIV) == 1 && (pos / CLK_DIV) >= 1 && (pos / CLK_DIV) <= 8)
        rx[(pos / CLK_DIV) - 1] = tx;
      if (pos == FRAME_CYC - 1) check("fill_rx_byte", rx, 8'h10 + 8'(c / FRAME_CYC));
    end
    tick();
    check("fill_drained_busy", busy, 0);
    check("fill_drained_count", fifo_count, 0);

    // back-to-back frames: one unbroken busy run
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    run = 0;
    for (int i = 0; i < 4 * FRAME_CYC; i++) begin
      if (busy) run++;
      else if (run > 0) break;
      tick();
    end
    check("b2b_busy_run", run, 2 * FRAME_CYC);

    // push on the same edge as the IDLE->START pop
    tx_en    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h30 + 8'(i);
      tick();
    end
    check("pushpop_pre_count", fifo_count, 3);
    in_data = 8'h33;
    tx_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pushpop_count", fifo_count, 3);
    check("pushpop_busy", busy, 1);
    wait_drain(5 * FRAME_CYC);

    // reset during DATA bit 3 of 0x52 (bit 3 = 0), one byte still buffered
    in_data  = 8'h52;
    in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    repeat (4 * CLK_DIV + 1) tick();
    check("midreset_pre_tx", tx, 0);
    check("midreset_pre_count", fifo_count, 1);
    #2;
    resetb = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_fifo_count", fifo_count, 0);
    check("midreset_in_ready", in_ready, 1);
    #3;
    resetb    = 1'b1;
    seen_busy = 1'b0;
    repeat (3 * FRAME_CYC) begin
      tick();
      if (busy || !tx) seen_busy = 1'b1;
    end
    check("midreset_no_frame", seen_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
